// File: rtl/hazard_sched_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and the
// interrupt entry sequence (drain, PC push, vector jump) for the 5-stage core.
// Drives the enable/flush controls of the F/D, D/E and E/M pipeline buffers.
module hazard_sched_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,  // legal range 1..7
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       dec_rsrc1,
    input  logic [2:0]       dec_rsrc2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic [2:0]       ex_rdst,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             branch_taken,
    input  logic             int_req,
    output logic             fetch_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             int_push,
    output logic             int_vec_sel,
    output logic             int_ack,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StPush,
        StVector
    } state_e;

    // Drain counter value on the final DRAIN cycle.
    localparam logic [2:0] DrainLast = 3'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       drain_cnt_q, drain_cnt_d;
    logic             armed_q, armed_d;
    logic             int_push_q, int_push_d;
    logic             int_vec_q, int_vec_d;
    logic             int_ack_q, int_ack_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu_hz;
    logic int_entry;

    // Load in execute whose result the decode instruction actually reads.
    assign lu_hz = ex_mem_read & ex_reg_write &
                   ((dec_use1 & (dec_rsrc1 == ex_rdst)) |
                    (dec_use2 & (dec_rsrc2 == ex_rdst)));

    // Entry only on a clean RUN cycle; branches and stalls defer it.
    assign int_entry = int_req & armed_q & ~branch_taken & ~lu_hz;

    // FSM next-state, drain counter, re-arm logic and next values of the int_* flags.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        armed_d     = armed_q;
        unique case (state_q)
            StRun: begin
                // Re-arm only once the request has been seen low.
                if (!int_req) begin
                    armed_d = 1'b1;
                end
                if (int_entry) begin
                    state_d     = StDrain;
                    drain_cnt_d = 3'd0;
                end
            end
            StDrain: begin
                if (drain_cnt_q == DrainLast) begin
                    state_d = StPush;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            StPush: begin
                state_d = StVector;
            end
            StVector: begin
                state_d = StRun;
                armed_d = 1'b0;
            end
            default: begin
                state_d = StRun;
            end
        endcase
        int_push_d = (state_d == StPush);
        int_vec_d  = (state_d == StVector);
        int_ack_d  = (state_d == StVector);
    end

    // FSM state with registered interrupt-handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            drain_cnt_q <= 3'd0;
            armed_q     <= 1'b1;
            int_push_q  <= 1'b0;
            int_vec_q   <= 1'b0;
            int_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            armed_q     <= armed_d;
            int_push_q  <= int_push_d;
            int_vec_q   <= int_vec_d;
            int_ack_q   <= int_ack_d;
        end
    end

    // Pipeline buffer controls; hazard/branch response is same-cycle in RUN.
    always_comb begin
        fetch_en = 1'b1;
        fd_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        em_flush = 1'b0;
        if (rst) begin
            fetch_en = 1'b0;
            fd_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    // Branch wins over load-use: the dependent instruction is flushed anyway.
                    if (branch_taken) begin
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (lu_hz) begin
                        fetch_en = 1'b0;
                        fd_en    = 1'b0;
                        de_flush = 1'b1;
                    end
                end
                StDrain, StPush: begin
                    fetch_en = 1'b0;
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                end
                StVector: begin
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                end
                default: begin
                    fetch_en = 1'b1;
                end
            endcase
        end
    end

    // Handshake flags come from flops only; reset masks them immediately.
    assign int_push    = int_push_q & ~rst;
    assign int_vec_sel = int_vec_q & ~rst;
    assign int_ack     = int_ack_q & ~rst;

    // Saturating count of cycles with fetch held off.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!fetch_en && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall performance counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed self-checking bench for hazard_sched_ctrl: table of combinational
// hazard/branch vectors plus hand-written interrupt, reset and saturation sequences.
module tb_hazard_sched_ctrl;

    // Output vector order: {fetch_en, fd_en, fd_flush, de_flush, em_flush,
    //                       int_push, int_vec_sel, int_ack}
    localparam logic [7:0] RstO   = 8'b0011_1000;
    localparam logic [7:0] RunO   = 8'b1100_0000;
    localparam logic [7:0] StallO = 8'b0001_0000;
    localparam logic [7:0] BrO    = 8'b1111_0000;
    localparam logic [7:0] DrnO   = 8'b0011_0000;
    localparam logic [7:0] PshO   = 8'b0011_0100;
    localparam logic [7:0] VecO   = 8'b1011_0011;
    localparam logic [7:0] All    = 8'hFF;
    localparam logic [7:0] NoFdEn = 8'b1011_1111;  // fd_en left free in interrupt states

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] dec_rsrc1, dec_rsrc2, ex_rdst;
    logic       dec_use1, dec_use2, ex_mem_read, ex_reg_write, branch_taken, int_req;

    logic        fetch_en, fd_en, fd_flush, de_flush, em_flush, int_push, int_vec_sel, int_ack;
    logic [15:0] stall_cnt;
    logic        s_fetch_en, s_fd_en, s_fd_flush, s_de_flush, s_em_flush;
    logic        s_int_push, s_int_vec_sel, s_int_ack;
    logic [3:0]  s_stall_cnt;

    hazard_sched_ctrl #(
        .DRAIN_CYCLES(3),
        .CNT_W       (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .dec_rsrc1   (dec_rsrc1),
        .dec_rsrc2   (dec_rsrc2),
        .dec_use1    (dec_use1),
        .dec_use2    (dec_use2),
        .ex_rdst     (ex_rdst),
        .ex_mem_read (ex_mem_read),
        .ex_reg_write(ex_reg_write),
        .branch_taken(branch_taken),
        .int_req     (int_req),
        .fetch_en    (fetch_en),
        .fd_en       (fd_en),
        .fd_flush    (fd_flush),
        .de_flush    (de_flush),
        .em_flush    (em_flush),
        .int_push    (int_push),
        .int_vec_sel (int_vec_sel),
        .int_ack     (int_ack),
        .stall_cnt   (stall_cnt)
    );

    // Narrow-counter instance sharing the stimulus, for saturation.
    hazard_sched_ctrl #(
        .DRAIN_CYCLES(3),
        .CNT_W       (4)
    ) u_sat (
        .clk         (clk),
        .rst         (rst),
        .dec_rsrc1   (dec_rsrc1),
        .dec_rsrc2   (dec_rsrc2),
        .dec_use1    (dec_use1),
        .dec_use2    (dec_use2),
        .ex_rdst     (ex_rdst),
        .ex_mem_read (ex_mem_read),
        .ex_reg_write(ex_reg_write),
        .branch_taken(branch_taken),
        .int_req     (int_req),
        .fetch_en    (s_fetch_en),
        .fd_en       (s_fd_en),
        .fd_flush    (s_fd_flush),
        .de_flush    (s_de_flush),
        .em_flush    (s_em_flush),
        .int_push    (s_int_push),
        .int_vec_sel (s_int_vec_sel),
        .int_ack     (s_int_ack),
        .stall_cnt   (s_stall_cnt)
    );

    typedef struct {
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       u1;
        logic       u2;
        logic [2:0] rd;
        logic       mr;
        logic       rw;
        logic       br;
        logic [3:0] exp;  // {fetch_en, fd_en, fd_flush, de_flush}
    } vec_t;

    vec_t vecs[11];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned es     = 0;  // expected stall count

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [7:0] exp, input logic [7:0] care);
        logic [7:0] act;
        act = {fetch_en, fd_en, fd_flush, de_flush, em_flush, int_push, int_vec_sel, int_ack};
        checks++;
        if (((act ^ exp) & care) !== 8'h00) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b (care %b)", name, act, exp, care);
        end
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_stall_cnt"}, {16'h0, stall_cnt}, es);
        chk({name, "_stall_cnt_sat"}, {28'h0, s_stall_cnt}, (es > 15) ? 32'd15 : es);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_rsrc1 = 3'd0; dec_rsrc2 = 3'd0; ex_rdst = 3'd0;
        dec_use1 = 1'b0; dec_use2 = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic set_lu();
        dec_rsrc2 = 3'd3; dec_use2 = 1'b1; ex_rdst = 3'd3;
        ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    endtask

    // Runs a full drain/push/vector sequence starting in the first DRAIN cycle.
    task automatic int_seq(input string name);
        for (int d = 0; d < 3; d++) begin
            @(negedge clk); chk_outs({name, "_drain"}, DrnO, NoFdEn); nxt();
        end
        @(negedge clk); chk_outs({name, "_push"}, PshO, NoFdEn); nxt();
        @(negedge clk); chk_outs({name, "_vector"}, VecO, NoFdEn); nxt();
        es += 4;
        chk_cnt(name);
    endtask

    initial begin
        vecs[0]  = '{3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 4'b1100};
        vecs[1]  = '{3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 4'b0001};
        vecs[2]  = '{3'd1, 3'd3, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 4'b1100};
        vecs[3]  = '{3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 4'b1100};
        vecs[4]  = '{3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 4'b1100};
        vecs[5]  = '{3'd5, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 4'b0001};
        vecs[6]  = '{3'd5, 3'd2, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 4'b1100};
        vecs[7]  = '{3'd4, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 4'b1100};
        vecs[8]  = '{3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 4'b1111};
        vecs[9]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 4'b1111};
        vecs[10] = '{3'd0, 3'd6, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 4'b0001};

        // Reset held for two edges.
        rst = 1'b1; int_req = 1'b0; idle();
        @(negedge clk); chk_outs("reset_c0", RstO, All);
        nxt();
        @(negedge clk); chk_outs("reset_c1", RstO, All);
        nxt();
        chk_cnt("reset");
        rst = 1'b0;
        @(negedge clk); chk_outs("run_default", RunO, All);
        nxt();

        // Combinational hazard/branch table.
        for (int i = 0; i < 11; i++) begin
            dec_rsrc1 = vecs[i].rs1; dec_rsrc2 = vecs[i].rs2;
            dec_use1 = vecs[i].u1; dec_use2 = vecs[i].u2; ex_rdst = vecs[i].rd;
            ex_mem_read = vecs[i].mr; ex_reg_write = vecs[i].rw; branch_taken = vecs[i].br;
            @(negedge clk); chk_outs($sformatf("vec%0d", i), {vecs[i].exp, 4'b0000}, All);
            if (!vecs[i].exp[3]) es++;
            nxt();
            chk_cnt($sformatf("vec%0d", i));
        end
        idle();

        // Interrupt entry with the request held afterwards.
        int_req = 1'b1;
        @(negedge clk); chk_outs("int_req_run", RunO, All);
        nxt();
        int_seq("int1");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk_outs("held_no_reentry", RunO, All);
            nxt();
        end
        int_req = 1'b0;
        @(negedge clk); chk_outs("int_low_rearm", RunO, All);
        nxt();
        int_req = 1'b1;
        @(negedge clk); chk_outs("int2_req_run", RunO, All);
        nxt();

        // Second entry, aborted by reset during PUSH.
        for (int d = 0; d < 3; d++) begin
            @(negedge clk); chk_outs("int2_drain", DrnO, NoFdEn); nxt();
        end
        @(negedge clk); chk_outs("int2_push", PshO, NoFdEn);
        rst = 1'b1;
        #1 chk_outs("reset_in_push", RstO, All);
        nxt();
        rst = 1'b0; es = 0;
        chk_cnt("reset_in_push");
        @(negedge clk); chk_outs("after_abort_run", RunO, All);
        nxt();
        int_seq("reentry_after_abort");
        int_req = 1'b0;
        @(negedge clk); chk_outs("rearm2", RunO, All);
        nxt();

        // Branch together with the request: flush now, entry on the next clean cycle.
        int_req = 1'b1; branch_taken = 1'b1;
        @(negedge clk); chk_outs("br_int", BrO, All);
        nxt();
        branch_taken = 1'b0;
        @(negedge clk); chk_outs("br_int_deferred", RunO, All);
        nxt();
        @(negedge clk); chk_outs("br_int_drain0", DrnO, NoFdEn);
        nxt();
        branch_taken = 1'b1;
        @(negedge clk); chk_outs("drain_ignores_branch", DrnO, NoFdEn);
        nxt();
        branch_taken = 1'b0;
        @(negedge clk); chk_outs("br_int_drain2", DrnO, NoFdEn);
        nxt();
        @(negedge clk); chk_outs("br_int_push", PshO, NoFdEn);
        nxt();
        @(negedge clk); chk_outs("br_int_vector", VecO, NoFdEn);
        nxt();
        es += 4;
        chk_cnt("br_int");
        int_req = 1'b0;
        @(negedge clk); chk_outs("rearm3", RunO, All);
        nxt();

        // Load-use together with the request: stall, entry deferred.
        set_lu(); int_req = 1'b1;
        @(negedge clk); chk_outs("lu_int", StallO, All);
        es++;
        nxt();
        idle();
        @(negedge clk); chk_outs("lu_int_deferred", RunO, All);
        nxt();
        int_seq("lu_int");
        int_req = 1'b0;

        // Long stall run: wide counter keeps counting, narrow one pins at 15.
        set_lu();
        for (int i = 0; i < 20; i++) begin
            nxt();
            es++;
            chk_cnt($sformatf("sat%0d", i));
        end
        idle();
        @(negedge clk); chk_outs("final_run", RunO, All);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_sched_ctrl.md
# hazard_sched_ctrl

Pipeline sequencing controller for the 5-stage core. It drives the enable and flush controls of the fetch/decode, decode/execute and execute/memory pipeline buffers. It handles three cases: load-use stalls, taken-branch flushes, and the interrupt entry sequence (drain, PC push, vector jump). It sits beside the forwarding unit and consumes decode- and execute-stage register fields, so the pipeline buffers no longer need hard-tied `enable=1`.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: number of bubble cycles inserted before the interrupt PC push; legal range 1..7.
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dec_rsrc1`, `dec_rsrc2`  in  3 each  source registers of the instruction in decode.
- `dec_use1`, `dec_use2`  in  1 each  the decode instruction actually reads that source.
- `ex_rdst`  in  3  destination register of the instruction in execute.
- `ex_mem_read`  in  1  the execute instruction is a load (memory-read writeback).
- `ex_reg_write`  in  1  the execute instruction writes the register file.
- `branch_taken`  in  1  execute resolved a taken branch/jump this cycle.
- `int_req`  in  1  level-sensitive interrupt request.
- `fetch_en`  out  1  PC register update enable.
- `fd_en`  out  1  fetch/decode buffer load enable.
- `fd_flush`  out  1  fetch/decode buffer loads a NOP.
- `de_flush`  out  1  decode/execute buffer loads a bubble (all control zero).
- `em_flush`  out  1  execute/memory buffer loads a bubble.
- `int_push`  out  1  memory stage pushes the saved PC (32-bit stack write).
- `int_vec_sel`  out  1  fetch selects the IVT vector as next PC.
- `int_ack`  out  1  one-cycle acknowledge to the interrupt source.
- `stall_cnt`  out  `CNT_W`  saturating count of cycles with `fetch_en` = 0.

## Operation
Hazard detection is combinational:
- `lu_hz` = `ex_mem_read` & `ex_reg_write` & ((`dec_use1` & `dec_rsrc1`==`ex_rdst`) | (`dec_use2` & `dec_rsrc2`==`ex_rdst`)).

FSM states: RUN, DRAIN, PUSH, VECTOR.
- **RUN, defaults:** `fetch_en`=`fd_en`=1, all flushes 0, all `int_*` 0.
- **RUN, `branch_taken`=1:** `fd_flush`=`de_flush`=1. `lu_hz` is ignored; branch has priority.
- **RUN, `lu_hz`=1 and no branch:** `fetch_en`=`fd_en`=0, `de_flush`=1. This stalls for exactly one cycle; forwarding from the memory stage covers the following cycle.
- **RUN → DRAIN:** when `int_req`=1, `armed`=1, `branch_taken`=0 and `lu_hz`=0. The drain counter loads 0.
  - If `branch_taken` or `lu_hz` is set, entry is deferred; `int_req` is re-evaluated every cycle.
- **DRAIN:** `fetch_en`=0, `fd_flush`=1, `de_flush`=1. The counter increments each cycle; after `DRAIN_CYCLES` cycles in DRAIN, go to PUSH. `branch_taken` is ignored here, because the instruction in execute was already committed before DRAIN.
- **PUSH:** `fetch_en`=0, `fd_flush`=`de_flush`=1, `int_push`=1 for exactly one cycle, then go to VECTOR.
- **VECTOR:** `fetch_en`=1, `int_vec_sel`=1, `int_ack`=1, `fd_flush`=1, `de_flush`=1 for one cycle; `armed` clears; return to RUN.
- **`armed` flag:** reset value 1; sets again only when `int_req` is sampled 0 in RUN. A request held high across the ack therefore causes a single entry.
- **`em_flush`:** asserted only while `rst`=1.
- **`stall_cnt`:** increments on each rising edge where `fetch_en`=0 and `rst`=0; saturates at all-ones and never wraps.

## Timing
- **Reset:** while `rst`=1, outputs are forced to `fetch_en`=0, `fd_en`=0, `fd_flush`=`de_flush`=`em_flush`=1, `int_push`=`int_vec_sel`=`int_ack`=0.
  - At the first edge with `rst`=1: state goes to RUN, the drain counter to 0, `armed` to 1, `stall_cnt` to 0.
  - Reset mid-sequence (DRAIN, PUSH or VECTOR) abandons the interrupt with no ack.
- **Latency:** hazard and branch outputs are combinational, valid in the same cycle as their inputs.
- **Interrupt sequence:** `int_req` seen in RUN at edge N gives DRAIN from N+1 to N+`DRAIN_CYCLES`, PUSH in cycle N+`DRAIN_CYCLES`+1, and VECTOR in N+`DRAIN_CYCLES`+2. Total cost is `DRAIN_CYCLES`+2 cycles.
- **Simultaneous events:**
  - Branch + `lu_hz`: flush only, no stall.
  - Branch + `int_req`: flush; interrupt entry is taken on the next eligible RUN cycle.
  - `lu_hz` + `int_req`: stall; entry is deferred.
- **Glitch-free outputs:** `int_push`, `int_vec_sel` and `int_ack` derive from state only.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles → `fetch_en`=0, all flushes 1, `stall_cnt`=0. After release → RUN defaults (`fetch_en`=1, `fd_en`=1, flushes 0).
- **Load-use:** `ex_mem_read`=`ex_reg_write`=1, `ex_rdst`=3, `dec_rsrc2`=3, `dec_use2`=1 for one cycle → in that same cycle `fetch_en`=0, `fd_en`=0, `de_flush`=1; `stall_cnt` becomes 1. With `dec_use2`=0, or with `ex_reg_write`=0 → no stall.
- **Branch priority:** `branch_taken`=1 together with the load-use condition above → `fd_flush`=`de_flush`=1, `fetch_en`=1, no stall.
- **Interrupt, `DRAIN_CYCLES`=3:** `int_req` rises in RUN at cycle 10 → DRAIN in cycles 11-13 (`fetch_en`=0), `int_push`=1 in cycle 14, `int_vec_sel`=`int_ack`=1 in cycle 15, RUN in cycle 16. `stall_cnt` increases by 4. Keeping `int_req` high afterwards → no second entry until it drops for at least 1 cycle.
- **Deferred entry:** `int_req`=1 together with `branch_taken`=1 at cycle 20 → flush only in cycle 20; DRAIN starts in cycle 21.
- **Reset mid-sequence and saturation:**
  - `rst` asserted during PUSH → `int_ack` never asserts; state is RUN after release; a held `int_req` re-enters because `armed` is 1.
  - `CNT_W`=4 with 20 stall cycles → `stall_cnt`=15.
